pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised successor to the fixed 5-field inter-stage pipeline register. It carries one WIDTH-bit payload between two pipeline stages with a valid/ready handshake, a synchronous flush that inserts a bubble, and a two-entry skid buffer. The buffer lets back-pressure from the downstream stage stop the upstream stage one cycle late without losing data. It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB, with the payload being the concatenated IR/PC4/operand fields of each boundary.

## Interface
- WIDTH, 160, payload width in bits (e.g. IR+PC4+RS+RT+EXT = 5×32).
- NOP_VALUE, '0, payload driven and stored whenever a slot is empty or flushed (all-zero IR = MIPS sll $0 nop).
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; resets all state.
- flush  input  1  synchronous bubble request; discards all held and incoming data.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  block can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a real instruction.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload to downstream; NOP_VALUE when out_valid=0.
- level  output  2  occupancy: 0, 1 or 2 entries.

## Operation
- Storage: main slot (drives out_data) and skid slot. State register: EMPTY, ONE, FULL.
- in_acc = in_valid & in_ready; out_acc = out_valid & out_ready.
- in_ready = !reset & (state != FULL). This is decoded from the state register only, with no combinational path from out_ready.
- out_valid = (state != EMPTY); level = 0/1/2 for EMPTY/ONE/FULL.
- EMPTY: in_acc → main<=in_data, ONE. Otherwise stay.
- ONE, in_acc & out_acc → main<=in_data, stay ONE.
- ONE, in_acc & !out_acc → skid<=in_data, FULL.
- ONE, !in_acc & out_acc → main<=NOP_VALUE, EMPTY.
- ONE, neither → hold.
- FULL: in_acc is impossible. out_acc → main<=skid, skid<=NOP_VALUE, ONE. Otherwise hold.
- Order is preserved: main is always older than skid.
- flush (priority over everything except reset): next state EMPTY, main and skid <= NOP_VALUE.
  - A beat offered during the flush cycle is dropped, even if in_ready=1.
  - out_acc in that cycle still counts as delivered to downstream. Downstream is responsible for squashing it.
- Empty slots always hold NOP_VALUE, so a stage reading out_data without checking out_valid sees a nop.
- No stored payload changes unless its slot is loaded or cleared by the rules above.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert in the system): state EMPTY, main=skid=NOP_VALUE, out_valid=0, level=0, out_data=NOP_VALUE, in_ready=0 while reset is high and 1 on the first cycle after.
- Latency: a beat accepted at edge N appears on out_data/out_valid after edge N; there is one register stage.
- Throughput: one beat per cycle sustained while out_ready=1.
- Back-pressure: out_ready low in cycle N → in_ready may still be 1 in cycle N (absorbed into skid). It drops after edge N only if that beat was accepted.
- Release: out_ready high in FULL → in_ready=1 the following cycle.
- Reset mid-transfer: all held beats are lost and no output toggles are guaranteed beyond the reset values.
- Simultaneous flush & reset: reset wins; the result is identical to reset.

## Structure
- Shared package pipe_pkg holds:
  - the state enum {EMPTY, ONE, FULL};
  - LEVEL_W=2;
  - the default NOP word constant (32'h0000_0000) used to build NOP_VALUE per boundary.
- One sub-module, pipe_slot: a WIDTH-bit register with load, load_value, clear-to-NOP_VALUE and async reset. It is instantiated twice (main, skid).
- The FSM and handshake decode live in the top.

## Test plan
- Streaming: out_ready=1, feed 0x1..0x8 on consecutive cycles → out_data 0x1..0x8 each one cycle later, level stays 1, in_ready stays 1.
- Back-pressure: feed 0xA,0xB,0xC with out_ready=0 from the cycle 0xB arrives:
  - level goes 1→2, in_ready=0, 0xC stays offered;
  - raise out_ready → outputs 0xA, 0xB, 0xC in order, with no loss or duplication.
- Flush while FULL (main=0xA, skid=0xB) with in_valid=1, in_data=0xC → next cycle level=0, out_valid=0, out_data=NOP_VALUE; 0xC is never output.
- Drain: ONE with 0x5, in_valid=0, out_ready=1 → after one edge out_valid=0, out_data=NOP_VALUE, level=0.
- Async reset asserted mid-cycle while FULL → outputs go to reset values immediately, with no clock edge required. in_ready=0 during reset and 1 the cycle after release.
- Random valid/ready/flush for 10k cycles against a reference queue model:
  - output order matches the model;
  - level never exceeds 2;
  - out_data=NOP_VALUE whenever out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register with skid buffer:
// occupancy states, level width and the default nop word.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int LEVEL_W = 2;

    // All-zero IR decodes as MIPS sll $0,$0,0.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [LEVEL_W-1:0] state_level(input state_t s);
        case (s)
            EMPTY:   return 2'd0;
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data handshake bundle for one side of a pipeline boundary.
interface pipe_stage_skid_if #(
    parameter int WIDTH = 160
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One payload register of the stage: async reset and synchronous clear both
// return it to the nop value; clear takes priority over load.
module pipe_slot import pipe_pkg::*; #(
    parameter int               WIDTH     = 160,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q
);

    // Payload storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= NOP_VALUE;
        end else if (clear) begin
            q <= NOP_VALUE;
        end else if (load) begin
            q <= load_value;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a two-entry skid buffer and flush.
// The main slot always holds the older beat and drives the downstream side.
module pipe_stage_skid import pipe_pkg::*; #(
    parameter int               WIDTH     = 160,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'({((WIDTH + 31) / 32){NOP_WORD}})
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    pipe_stage_skid_if.slave       up,
    pipe_stage_skid_if.master      dn,
    output logic [LEVEL_W-1:0]     level
);

    state_t           state_r;
    state_t           state_s;
    logic             in_ready_s;
    logic             in_acc_s;
    logic             out_acc_s;
    logic             main_load_s;
    logic             main_clr_s;
    logic [WIDTH-1:0] main_val_s;
    logic             skid_load_s;
    logic             skid_clr_s;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Ready is decoded from state only so out_ready never reaches in_ready.
    assign in_ready_s = !reset && (state_r != FULL);
    assign in_acc_s   = up.valid && in_ready_s;
    assign out_acc_s  = (state_r != EMPTY) && dn.ready;

    assign up.ready = in_ready_s;
    assign dn.valid = (state_r != EMPTY);
    assign dn.data  = main_q;
    assign level    = state_level(state_r);

    // Occupancy state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and slot controls
    always_comb begin
        state_s     = state_r;
        main_load_s = 1'b0;
        main_clr_s  = 1'b0;
        main_val_s  = up.data;
        skid_load_s = 1'b0;
        skid_clr_s  = 1'b0;
        if (flush) begin
            state_s    = EMPTY;
            main_clr_s = 1'b1;
            skid_clr_s = 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_acc_s) begin
                        main_load_s = 1'b1;
                        state_s     = ONE;
                    end else begin
                        state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (in_acc_s && out_acc_s) begin
                        main_load_s = 1'b1;
                    end else if (in_acc_s) begin
                        skid_load_s = 1'b1;
                        state_s     = FULL;
                    end else if (out_acc_s) begin
                        main_clr_s = 1'b1;
                        state_s    = EMPTY;
                    end else begin
                        state_s = ONE;
                    end
                end
                FULL: begin
                    // The skid beat is younger, so it moves up into main.
                    if (out_acc_s) begin
                        main_load_s = 1'b1;
                        main_val_s  = skid_q;
                        skid_clr_s  = 1'b1;
                        state_s     = ONE;
                    end else begin
                        state_s = FULL;
                    end
                end
                default: begin
                    state_s    = EMPTY;
                    main_clr_s = 1'b1;
                    skid_clr_s = 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_main (
        .clk        (clk),
        .reset      (reset),
        .clear      (main_clr_s),
        .load       (main_load_s),
        .load_value (main_val_s),
        .q          (main_q)
    );

    pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .clear      (skid_clr_s),
        .load       (skid_load_s),
        .load_value (up.data),
        .q          (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random
// valid/ready/flush traffic compared against a queue reference model.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int          W   = 64;
    localparam logic [W-1:0] NOP = 64'hF00D_0000_0000_0001;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic [LEVEL_W-1:0] level;

    int tests = 0;
    int failures = 0;
    logic [W-1:0] q[$];

    pipe_stage_skid_if #(.WIDTH(W)) up ();
    pipe_stage_skid_if #(.WIDTH(W)) dn ();

    pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .up    (up),
        .dn    (dn),
        .level (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with what the reference queue implies.
    task automatic check_outputs();
        int n;
        n = q.size();
        check("out_valid", W'(dn.valid), W'(n != 0));
        check("out_data", dn.data, (n != 0) ? q[0] : NOP);
        check("level", W'(level), W'(n));
        check("in_ready", W'(up.ready), W'(!reset && (n < 2)));
    endtask

    // Check at the falling edge, advance the model, then cross the rising edge.
    task automatic tick();
        int  n;
        logic acc_in;
        @(negedge clk);
        check_outputs();
        n = q.size();
        if (reset) begin
            q.delete();
        end else begin
            acc_in = up.valid && (n < 2);
            if (flush) begin
                q.delete();
            end else begin
                if (n != 0 && dn.ready) void'(q.pop_front());
                if (acc_in) q.push_back(up.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        up.valid = v;
        up.data  = d;
        dn.ready = r;
        flush    = f;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        check("reset_in_ready", W'(up.ready), W'(1'b0));
        check("reset_out_data", dn.data, NOP);
        tick();
        reset = 1'b0;
        tick();

        // Streaming 1..8 with downstream always ready
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            tick();
        end
        check("stream_last", dn.data, W'(8));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tick();

        // Back-pressure: A, B, C with out_ready low from B onwards
        drive(1'b1, W'(64'hA), 1'b0, 1'b0);
        tick();
        drive(1'b1, W'(64'hB), 1'b0, 1'b0);
        tick();
        drive(1'b1, W'(64'hC), 1'b0, 1'b0);
        tick();
        check("bp_full_level", W'(level), W'(2));
        check("bp_full_ready", W'(up.ready), W'(1'b0));
        drive(1'b1, W'(64'hC), 1'b1, 1'b0);
        tick();
        check("bp_out_b", dn.data, W'(64'hB));
        tick();
        check("bp_out_c", dn.data, W'(64'hC));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("bp_drained", W'(dn.valid), W'(1'b0));

        // Flush while full, with 0xC offered in the same cycle
        drive(1'b1, W'(64'hA), 1'b0, 1'b0);
        tick();
        drive(1'b1, W'(64'hB), 1'b0, 1'b0);
        tick();
        drive(1'b1, W'(64'hC), 1'b0, 1'b1);
        tick();
        check("flush_level", W'(level), W'(0));
        check("flush_data", dn.data, NOP);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();

        // Drain a single beat
        drive(1'b1, W'(64'h5), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("drain_valid", W'(dn.valid), W'(1'b0));
        tick();

        // Asynchronous reset in the middle of a cycle while full
        drive(1'b1, W'(64'h11), 1'b0, 1'b0);
        tick();
        drive(1'b1, W'(64'h22), 1'b0, 1'b0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", W'(dn.valid), W'(1'b0));
        check("areset_level", W'(level), W'(0));
        check("areset_data", dn.data, NOP);
        check("areset_ready", W'(up.ready), W'(1'b0));
        q.delete();
        @(posedge clk);
        #1;
        tick();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();

        // Random traffic against the queue model
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
